// File: rtl/spi_display_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// spi_display_ctrl_pkg
// Shared types and constants for the display SPI transaction controller.
//   state_t  : controller FSM states
//   owner_t  : which requester currently owns the packet (NONE/CMD/PIX)
//   DC_CMD / DC_DATA : levels of the display data/command line
//   DEF_CS_* : default chip-select timing in clock cycles
// -----------------------------------------------------------------------------
package spi_display_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOAD,
        ST_WAIT,
        ST_HOLD,
        ST_GAP
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CMD,
        OWN_PIX
    } owner_t;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    localparam int DEF_CS_SETUP_CYC = 2;
    localparam int DEF_CS_HOLD_CYC  = 2;
    localparam int DEF_CS_GAP_CYC   = 4;

    // The timers count down to zero, so a duration of N cycles loads N-1.
    function automatic logic [3:0] cyc_to_load(input int cyc);
        return 4'(cyc - 1);
    endfunction

endpackage

// File: rtl/spi_display_ctrl_if.sv
// -----------------------------------------------------------------------------
// spi_display_ctrl_if
// Bundles the requester handshakes, the byte-wide SPI master handshake and
// the display pins of the controller.
//   cmd_*   : command/parameter requester (valid/ready, byte, dc, last)
//   pix_*   : pixel requester (valid/ready, RGB565 pixel, last)
//   spi_*   : byte interface towards the SPI master
//   cs_n/dc : display chip-select and data/command line
//   ctrl_busy : controller is not idle
// Modports:
//   slave  : the controller itself
//   master : the surrounding front-end and SPI master
// -----------------------------------------------------------------------------
interface spi_display_ctrl_if;

    logic        cmd_valid;
    logic [7:0]  cmd_data;
    logic        cmd_dc;
    logic        cmd_last;
    logic        cmd_ready;

    logic        pix_valid;
    logic [15:0] pix_data;
    logic        pix_last;
    logic        pix_ready;

    logic        spi_start;
    logic [7:0]  spi_data;
    logic        spi_busy;
    logic        spi_new_data;

    logic        cs_n;
    logic        dc;
    logic        ctrl_busy;

    modport slave (
        input  cmd_valid, cmd_data, cmd_dc, cmd_last,
        output cmd_ready,
        input  pix_valid, pix_data, pix_last,
        output pix_ready,
        output spi_start, spi_data,
        input  spi_busy, spi_new_data,
        output cs_n, dc, ctrl_busy
    );

    modport master (
        output cmd_valid, cmd_data, cmd_dc, cmd_last,
        input  cmd_ready,
        output pix_valid, pix_data, pix_last,
        input  pix_ready,
        input  spi_start, spi_data,
        output spi_busy, spi_new_data,
        input  cs_n, dc, ctrl_busy
    );

endinterface

// File: rtl/spi_display_ctrl_cs_timer.sv
// -----------------------------------------------------------------------------
// spi_display_ctrl_cs_timer
// 4-bit load / count-down timer shared by the chip-select setup, hold and gap
// phases. It saturates at zero and never wraps.
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : load value_i this cycle (takes precedence over counting)
//   value_i    : count to load
//   done_o     : count has reached zero
// -----------------------------------------------------------------------------
module spi_display_ctrl_cs_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [3:0] value_i,
    output logic       done_o
);

    logic [3:0] cnt_q;

    // Load on request, otherwise step down until zero and stay there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else if (load_i) begin
            cnt_q <= value_i;
        end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign done_o = (cnt_q == 4'd0);

endmodule

// File: rtl/spi_display_ctrl.sv
// -----------------------------------------------------------------------------
// spi_display_ctrl
// Arbitrates between the command and pixel requesters, frames each packet
// with chip-select, drives the display dc line and hands bytes one at a time
// to the SPI master. Pixels go out high byte first.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : controller side (slave modport) of spi_display_ctrl_if
// Parameters CS_SETUP_CYC / CS_HOLD_CYC / CS_GAP_CYC (1..15) set the
// chip-select setup, hold and minimum inter-packet gap in cycles.
// -----------------------------------------------------------------------------
module spi_display_ctrl
    import spi_display_ctrl_pkg::*;
#(
    parameter int CS_SETUP_CYC = DEF_CS_SETUP_CYC,
    parameter int CS_HOLD_CYC  = DEF_CS_HOLD_CYC,
    parameter int CS_GAP_CYC   = DEF_CS_GAP_CYC
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_display_ctrl_if.slave  bus
);

    state_t     state_q;
    owner_t     owner_q;
    logic       phase_lo_q;
    logic       last_q;
    logic [7:0] pix_lo_q;
    logic [7:0] spi_data_q;
    logic       dc_q;
    logic       cs_n_q;

    logic       cmd_fire;
    logic       pix_hi_fire;
    logic       pix_lo_fire;
    logic       start;
    logic [7:0] byte_d;
    logic       dc_d;
    logic       going_hold;
    logic       tmr_load;
    logic [3:0] tmr_value;
    logic       tmr_done;

    spi_display_ctrl_cs_timer u_cs_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (tmr_load),
        .value_i (tmr_value),
        .done_o  (tmr_done)
    );

    // Handshakes are combinational so that ready, spi_start and the byte on
    // spi_data all fall in the single cycle in which the requester's data is
    // sampled. Nothing starts while the SPI master is still busy.
    assign cmd_fire    = (state_q == ST_LOAD) && (owner_q == OWN_CMD) &&
                         bus.cmd_valid && !bus.spi_busy;
    assign pix_hi_fire = (state_q == ST_LOAD) && (owner_q == OWN_PIX) &&
                         !phase_lo_q && bus.pix_valid && !bus.spi_busy;
    assign pix_lo_fire = (state_q == ST_LOAD) && (owner_q == OWN_PIX) &&
                         phase_lo_q && !bus.spi_busy;
    assign start       = cmd_fire || pix_hi_fire || pix_lo_fire;

    // A packet ends after a byte flagged last completes, but for pixels only
    // once the low byte has gone out.
    assign going_hold  = (state_q == ST_WAIT) && bus.spi_new_data && last_q &&
                         ((owner_q == OWN_CMD) || phase_lo_q);

    // Select the byte and dc level presented with a start pulse.
    always_comb begin
        byte_d = spi_data_q;
        dc_d   = dc_q;
        if (cmd_fire) begin
            byte_d = bus.cmd_data;
            dc_d   = bus.cmd_dc;
        end else if (pix_hi_fire) begin
            byte_d = bus.pix_data[15:8];
            dc_d   = DC_DATA;
        end else if (pix_lo_fire) begin
            byte_d = pix_lo_q;
            dc_d   = DC_DATA;
        end
    end

    // The shared timer is loaded on entry to SETUP, HOLD and GAP.
    always_comb begin
        tmr_load  = 1'b0;
        tmr_value = 4'd0;
        if ((state_q == ST_IDLE) && (bus.cmd_valid || bus.pix_valid)) begin
            tmr_load  = 1'b1;
            tmr_value = cyc_to_load(CS_SETUP_CYC);
        end else if (going_hold) begin
            tmr_load  = 1'b1;
            tmr_value = cyc_to_load(CS_HOLD_CYC);
        end else if ((state_q == ST_HOLD) && tmr_done) begin
            tmr_load  = 1'b1;
            tmr_value = cyc_to_load(CS_GAP_CYC);
        end
    end

    // Main controller FSM. Ownership is decided only in IDLE (command wins)
    // and held until GAP finishes. spi_data and dc are captured on every
    // start so they stay put through WAIT and after the packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_NONE;
            phase_lo_q <= 1'b0;
            last_q     <= 1'b0;
            pix_lo_q   <= 8'd0;
            spi_data_q <= 8'd0;
            dc_q       <= DC_CMD;
            cs_n_q     <= 1'b1;
        end else begin
            if (start) begin
                spi_data_q <= byte_d;
                dc_q       <= dc_d;
            end
            case (state_q)
                ST_IDLE: begin
                    phase_lo_q <= 1'b0;
                    if (bus.cmd_valid) begin
                        owner_q <= OWN_CMD;
                        state_q <= ST_SETUP;
                        cs_n_q  <= 1'b0;
                    end else if (bus.pix_valid) begin
                        owner_q <= OWN_PIX;
                        state_q <= ST_SETUP;
                        cs_n_q  <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    if (tmr_done) begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (cmd_fire) begin
                        last_q  <= bus.cmd_last;
                        state_q <= ST_WAIT;
                    end else if (pix_hi_fire) begin
                        pix_lo_q <= bus.pix_data[7:0];
                        last_q   <= bus.pix_last;
                        state_q  <= ST_WAIT;
                    end else if (pix_lo_fire) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.spi_new_data) begin
                        if ((owner_q == OWN_PIX) && !phase_lo_q) begin
                            phase_lo_q <= 1'b1;
                            state_q    <= ST_LOAD;
                        end else if (going_hold) begin
                            phase_lo_q <= 1'b0;
                            state_q    <= ST_HOLD;
                        end else begin
                            phase_lo_q <= 1'b0;
                            state_q    <= ST_LOAD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tmr_done) begin
                        cs_n_q  <= 1'b1;
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (tmr_done) begin
                        owner_q <= OWN_NONE;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.spi_start = start;
    assign bus.spi_data  = byte_d;
    assign bus.dc        = dc_d;
    assign bus.cmd_ready = cmd_fire;
    assign bus.pix_ready = pix_hi_fire;
    assign bus.cs_n      = cs_n_q;
    assign bus.ctrl_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_display_ctrl
// Directed bench for spi_display_ctrl with a behavioural SPI master and a
// scoreboard of expected {byte, dc} pairs in the order the display must see
// them.
// -----------------------------------------------------------------------------
module tb_spi_display_ctrl;

    localparam int SETUP   = 2;
    localparam int HOLD    = 2;
    localparam int GAP     = 4;
    localparam int SPI_LEN = 8;
    localparam int BUDGET  = 3000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    spi_display_ctrl_if bus();

    spi_display_ctrl #(
        .CS_SETUP_CYC (SETUP),
        .CS_HOLD_CYC  (HOLD),
        .CS_GAP_CYC   (GAP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       dc;
    } exp_t;

    exp_t sb[$];

    int tests       = 0;
    int fails       = 0;
    int cyc         = 0;
    int raise_cyc   = 0;
    int fall_cyc    = 0;
    int rise_cyc    = 0;
    int start_cyc   = 0;
    int nd_cyc      = 0;
    int gap_len     = 0;
    int rise_cnt    = 0;
    int cmd_rdy_cnt = 0;
    int pix_rdy_cnt = 0;
    int spi_cnt;
    logic prev_cs   = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SPI master: busy for SPI_LEN cycles after a start, then a
    // one-cycle byte-complete pulse.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.spi_busy     <= 1'b0;
            bus.spi_new_data <= 1'b0;
            spi_cnt          <= 0;
        end else begin
            bus.spi_new_data <= 1'b0;
            if (bus.spi_start) begin
                bus.spi_busy <= 1'b1;
                spi_cnt      <= SPI_LEN;
            end else if (spi_cnt == 1) begin
                bus.spi_busy     <= 1'b0;
                bus.spi_new_data <= 1'b1;
                spi_cnt          <= 0;
            end else if (spi_cnt > 1) begin
                spi_cnt <= spi_cnt - 1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor sampled on the falling edge: chip-select edges, byte starts
    // against the scoreboard, and ready pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_cs && !bus.cs_n) begin
                fall_cyc = cyc;
                gap_len  = cyc - rise_cyc;
            end
            if (!prev_cs && bus.cs_n) begin
                rise_cyc = cyc;
                rise_cnt++;
            end
            if (bus.spi_new_data) nd_cyc = cyc;
            if (bus.cmd_ready) begin
                cmd_rdy_cnt++;
                checkOutput("cmd_ready_with_start", 32'(bus.spi_start), 32'd1);
            end
            if (bus.pix_ready) begin
                pix_rdy_cnt++;
                checkOutput("pix_ready_with_start", 32'(bus.spi_start), 32'd1);
            end
            if (bus.spi_start) begin
                exp_t e;
                start_cyc = cyc;
                checkOutput("start_not_busy", 32'(bus.spi_busy), 32'd0);
                checkOutput("start_cs_low", 32'(bus.cs_n), 32'd0);
                if (sb.size() == 0) begin
                    checkOutput("sb_unexpected_byte", 32'(bus.spi_data), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    checkOutput("sb_data", 32'(bus.spi_data), 32'(e.data));
                    checkOutput("sb_dc", 32'(bus.dc), 32'(e.dc));
                end
            end
        end
        prev_cs = bus.cs_n;
    end

    task automatic applyStimulus(input logic [7:0] d, input logic dcv, input logic last);
        int   n;
        logic got;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = d;
        bus.cmd_dc    = dcv;
        bus.cmd_last  = last;
        raise_cyc     = cyc;
        n   = 0;
        got = 1'b0;
        while (!got && n < BUDGET) begin
            @(negedge clk);
            got = bus.cmd_ready;
            n++;
        end
        checkOutput("cmd_accept", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'h00;
        bus.cmd_last  = 1'b0;
    endtask

    task automatic applyPixel(input logic [15:0] p, input logic last);
        int   n;
        logic got;
        bus.pix_valid = 1'b1;
        bus.pix_data  = p;
        bus.pix_last  = last;
        n   = 0;
        got = 1'b0;
        while (!got && n < BUDGET) begin
            @(negedge clk);
            got = bus.pix_ready;
            n++;
        end
        checkOutput("pix_accept", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        bus.pix_valid = 1'b0;
        bus.pix_data  = 16'h0000;
        bus.pix_last  = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.ctrl_busy && n < BUDGET);
        checkOutput("idle_reached", 32'(bus.ctrl_busy), 32'd0);
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic dcv);
        exp_t e;
        e.data = d;
        e.dc   = dcv;
        return e;
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int r0;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'h00;
        bus.cmd_dc    = 1'b0;
        bus.cmd_last  = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_data  = 16'h0000;
        bus.pix_last  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_cs_n", 32'(bus.cs_n), 32'd1);
        checkOutput("rst_dc", 32'(bus.dc), 32'd0);
        checkOutput("rst_spi_start", 32'(bus.spi_start), 32'd0);
        checkOutput("rst_spi_data", 32'(bus.spi_data), 32'd0);
        checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        checkOutput("rst_pix_ready", 32'(bus.pix_ready), 32'd0);
        checkOutput("rst_ctrl_busy", 32'(bus.ctrl_busy), 32'd0);

        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] single command 0x2A");
        sb.push_back(mk(8'h2A, 1'b0));
        applyStimulus(8'h2A, 1'b0, 1'b1);
        waitIdle();
        checkOutput("cs_fall_latency", 32'(fall_cyc - raise_cyc), 32'd1);
        checkOutput("cs_setup", 32'(start_cyc - fall_cyc), 32'(SETUP));
        checkOutput("cs_hold", 32'(rise_cyc - nd_cyc), 32'(HOLD + 1));

        $display("[TB] three-byte command packet");
        r0 = rise_cnt;
        sb.push_back(mk(8'h2C, 1'b0));
        sb.push_back(mk(8'h12, 1'b1));
        sb.push_back(mk(8'h34, 1'b1));
        applyStimulus(8'h2C, 1'b0, 1'b0);
        applyStimulus(8'h12, 1'b1, 1'b0);
        applyStimulus(8'h34, 1'b1, 1'b1);
        waitIdle();
        checkOutput("cmd_ready_count_pkt", 32'(cmd_rdy_cnt), 32'd4);
        checkOutput("cs_low_across_pkt", 32'(rise_cnt - r0), 32'd1);

        $display("[TB] single pixel 0xF81F");
        sb.push_back(mk(8'hF8, 1'b1));
        sb.push_back(mk(8'h1F, 1'b1));
        applyPixel(16'hF81F, 1'b1);
        waitIdle();
        checkOutput("pix_ready_count_one", 32'(pix_rdy_cnt), 32'd1);

        $display("[TB] simultaneous command and pixel requests");
        sb.push_back(mk(8'hA5, 1'b0));
        sb.push_back(mk(8'h07, 1'b1));
        sb.push_back(mk(8'hE0, 1'b1));
        fork
            applyStimulus(8'hA5, 1'b0, 1'b1);
            applyPixel(16'h07E0, 1'b1);
        join
        waitIdle();
        checkOutput("gap_after_cmd", 32'(gap_len), 32'(GAP + 1));

        $display("[TB] pixel request mid command packet");
        sb.push_back(mk(8'h2C, 1'b0));
        sb.push_back(mk(8'hAA, 1'b1));
        sb.push_back(mk(8'hBB, 1'b1));
        sb.push_back(mk(8'h12, 1'b1));
        sb.push_back(mk(8'h34, 1'b1));
        fork
            begin
                applyStimulus(8'h2C, 1'b0, 1'b0);
                applyStimulus(8'hAA, 1'b1, 1'b0);
                applyStimulus(8'hBB, 1'b1, 1'b1);
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                applyPixel(16'h1234, 1'b1);
            end
        join
        waitIdle();
        checkOutput("gap_before_pix", 32'(gap_len), 32'(GAP + 1));

        $display("[TB] reset during second byte");
        sb.push_back(mk(8'h2B, 1'b0));
        sb.push_back(mk(8'h77, 1'b1));
        applyStimulus(8'h2B, 1'b0, 1'b0);
        applyStimulus(8'h77, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_cs_n", 32'(bus.cs_n), 32'd1);
        checkOutput("mid_rst_spi_start", 32'(bus.spi_start), 32'd0);
        checkOutput("mid_rst_ctrl_busy", 32'(bus.ctrl_busy), 32'd0);
        checkOutput("mid_rst_dc", 32'(bus.dc), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back(mk(8'h01, 1'b0));
        applyStimulus(8'h01, 1'b0, 1'b1);
        waitIdle();

        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        checkOutput("cmd_ready_total", 32'(cmd_rdy_cnt), 32'd11);
        checkOutput("pix_ready_total", 32'(pix_rdy_cnt), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_display_ctrl.md
# spi_display_ctrl

Transaction controller between the display front-end logic and the byte-wide SPI master. It arbitrates between a command/parameter requester and a pixel-stream requester, frames each packet with chip-select, drives the display's data/command line, and issues one byte at a time to the SPI master. Each 16-bit pixel is serialised high byte first.

## Interface
- `CS_SETUP_CYC`, default 2: cycles `cs_n` is low before the first `spi_start` of a packet (range 1..15).
- `CS_HOLD_CYC`, default 2: cycles `cs_n` stays low after the last byte's `spi_new_data` (range 1..15).
- `CS_GAP_CYC`, default 4: minimum cycles `cs_n` stays high between packets (range 1..15).
- `clk  in  1  system clock; all logic on rising edge`
- `rst  in  1  asynchronous, active-low reset`
- `cmd_valid  in  1  command byte available`
- `cmd_data  in  8  command/parameter byte`
- `cmd_dc  in  1  value for `dc` for this byte (0=command, 1=parameter)`
- `cmd_last  in  1  byte ends the command packet`
- `cmd_ready  out  1  one-cycle pulse: byte accepted`
- `pix_valid  in  1  pixel available`
- `pix_data  in  16  RGB565 pixel`
- `pix_last  in  1  pixel ends the pixel packet`
- `pix_ready  out  1  one-cycle pulse: pixel accepted (latched)`
- `spi_start  out  1  one-cycle start to SPI master`
- `spi_data  out  8  byte to SPI master, valid with `spi_start``
- `spi_busy  in  1  SPI master busy`
- `spi_new_data  in  1  SPI master byte-complete pulse`
- `cs_n  out  1  display chip-select, active low`
- `dc  out  1  display data/command`
- `ctrl_busy  out  1  high in every state except IDLE`

## Operation
- Reset values: `cs_n`=1, `dc`=0, `spi_start`=0, `spi_data`=0, `cmd_ready`=0, `pix_ready`=0, `ctrl_busy`=0; state IDLE; owner none; counters 0.
- States: IDLE, SETUP, LOAD, WAIT, HOLD, GAP.
- IDLE: if `cmd_valid`, owner=CMD; else if `pix_valid`, owner=PIX; then go to SETUP. Priority is fixed, CMD over PIX, and is evaluated only in IDLE. Ownership is never preempted mid-packet.
- SETUP: `cs_n`=0. Count `CS_SETUP_CYC` cycles, then go to LOAD.
- LOAD for CMD: wait for `cmd_valid` && !`spi_busy`. Then pulse `spi_start` and `cmd_ready`, drive `spi_data`=`cmd_data`, `dc`=`cmd_dc`, latch `cmd_last`, and go to WAIT.
- LOAD for PIX, high-byte phase: wait for `pix_valid` && !`spi_busy`. Then latch `pix_data` and `pix_last`, pulse `pix_ready` and `spi_start`, drive `spi_data`=`pix_data[15:8]`, `dc`=1, and go to WAIT.
- LOAD for PIX, low-byte phase: `spi_start` with `spi_data`=latched `[7:0]`. No handshake on this byte.
- WAIT: hold `spi_data` and `dc`. On `spi_new_data`:
  - PIX high phase: go to low phase, back to LOAD.
  - Latched last && (CMD or PIX low phase): go to HOLD.
  - Otherwise: back to LOAD.
- HOLD: `cs_n` stays 0 for `CS_HOLD_CYC` cycles, then `cs_n`=1 and go to GAP.
- GAP: count `CS_GAP_CYC` cycles, then go to IDLE, owner none.
- `dc` keeps its last driven value outside LOAD/WAIT.
- If the owner deasserts valid mid-packet, the controller stays in LOAD with `cs_n`=0 indefinitely. The other requester is not served.
- `spi_new_data` outside WAIT is ignored. `spi_start` is never issued while `spi_busy`=1.
- Async reset mid-packet returns all outputs to reset values immediately. The system resets the SPI master in the same event; the partial byte is discarded.

## Timing
- IDLE sees valid at cycle t: `cs_n` falls at t+1 and the first `spi_start` is at t+1+`CS_SETUP_CYC` at the earliest.
- Ready pulses coincide with `spi_start`. Data must be stable in that cycle only.
- Byte-to-byte gap inside a packet is 1 cycle after `spi_new_data` (WAIT→LOAD→start).
- After the last `spi_new_data` at cycle u:
  - `cs_n` rises at u+1+`CS_HOLD_CYC`.
  - Next IDLE is at u+1+`CS_HOLD_CYC`+`CS_GAP_CYC`.
  - Next `cs_n` fall is one cycle after that, at the earliest.
- Counters are 4 bits and count down from parameter−1; there is no wrap-around.

## Structure
- A shared `display_pkg` holds the state enumeration, owner encoding (NONE/CMD/PIX), `DC_CMD`=0 / `DC_DATA`=1, and default CS timing constants.
- One sub-module, `cs_timer`: a 4-bit load/count-down timer with a `done` flag, shared by SETUP, HOLD and GAP.
- Arbitration, serialiser and FSM stay in the top module.

## Test plan
- Single command 0x2A, `cmd_dc`=0, last=1, with the real SPI master:
  - `cs_n` falls, `spi_start` is issued 2 cycles later with `spi_data`=0x2A and `dc`=0.
  - MOSI shows 0x2A MSB first.
  - `cs_n` rises 3 cycles after `spi_new_data`.
- Command packet 0x2C (dc=0) then 0x12, 0x34 (dc=1, last on 0x34):
  - Three `cmd_ready` pulses, `dc` sequence 0,1,1.
  - `cs_n` stays low across all three bytes.
- Pixel 0xF81F, last=1:
  - One `pix_ready` pulse; bytes 0xF8 then 0x1F, `dc`=1.
  - `pix_data` changes to 0x0000 after ready; the low byte is still 0x1F.
- `cmd_valid` and `pix_valid` rise in the same cycle:
  - CMD is granted and its packet completes first.
  - PIX starts only after the `CS_GAP_CYC` gap with `cs_n` high.
- `pix_valid` is raised mid command packet: no pixel byte is issued until the command packet's last byte and GAP complete.
- Reset asserted during WAIT of the second byte:
  - `cs_n`=1, `spi_start`=0, `ctrl_busy`=0 immediately.
  - After release, a new command 0x01 is sent cleanly.
